// File: rtl/ssm_fpmul_pack.sv
// ssm_fpmul_pack: pack stage of the static-segment approximate FP multiplier.
// Normalizes the approximate fraction product, rounds, resolves specials and
// emits an IEEE-754 binary32 word through a two-stage elastic pipeline.
// Build option: define SSM_FPMUL_RNE_EN for round-to-nearest-even; otherwise
// the mantissa is truncated (inexact is still reported).
module ssm_fpmul_pack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign_a,
    input  logic                   in_sign_b,
    input  logic [EXP_W-1:0]       in_exp_a,
    input  logic [EXP_W-1:0]       in_exp_b,
    input  logic [MAN_W+2:0]       in_ris,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic [3:0]             out_flags
);

    localparam int EW = EXP_W + 2;   // two's-complement working exponent
    localparam int FW = MAN_W + 4;   // 2^MAN_W + ris
    localparam int RW = EXP_W + MAN_W + 1;
    localparam logic [EXP_W-1:0] EXP_MAX  = {EXP_W{1'b1}};
    localparam logic [EW-1:0]    EXP_OVF  = EW'((1 << EXP_W) - 1);
    localparam logic [RW-1:0]    QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_NAN  = 2'd1,
        CLS_INF  = 2'd2,
        CLS_ZERO = 2'd3
    } cls_e;

    // stage 1 state
    logic             s1_valid_q;
    logic             s1_sign_q;
    logic [EW-1:0]    s1_exp_q;
    logic [MAN_W:0]   s1_mant_q;
    logic             s1_guard_q;
    logic             s1_sticky_q;
    cls_e             s1_cls_q;

    // stage 2 state
    logic             s2_valid_q;
    logic [RW-1:0]    s2_result_q;
    logic [3:0]       s2_flags_q;

    logic s1_adv, s2_en;

    assign s1_adv   = s1_valid_q & (!s2_valid_q | out_ready);
    assign in_ready = !s1_valid_q | s1_adv;
    assign s2_en    = !s2_valid_q | out_ready;

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_flags  = s2_flags_q;

    // stage 1 next-state
    logic             s1_sign_d;
    logic [EW-1:0]    s1_exp_d;
    logic [MAN_W:0]   s1_mant_d;
    logic             s1_guard_d;
    logic             s1_sticky_d;
    cls_e             s1_cls_d;
    logic [FW-1:0]    full;
    logic [1:0]       shift;

    // Normalize the product (hidden 1 added) and classify the operands by exponent.
    always_comb begin
        full        = {{(FW-1-MAN_W){1'b0}}, 1'b1, {MAN_W{1'b0}}} + {1'b0, in_ris};
        s1_sign_d   = in_sign_a ^ in_sign_b;
        shift       = 2'd0;
        s1_mant_d   = full[MAN_W:0];
        s1_guard_d  = 1'b0;
        s1_sticky_d = 1'b0;
        if (|full[FW-1:FW-2]) begin
            shift       = 2'd2;
            s1_mant_d   = full[MAN_W+2:2];
            s1_guard_d  = full[1];
            s1_sticky_d = full[0];
        end else if (full[FW-3]) begin
            shift       = 2'd1;
            s1_mant_d   = full[MAN_W+1:1];
            s1_guard_d  = full[0];
        end
        s1_exp_d = EW'(in_exp_a) + EW'(in_exp_b) - EW'(BIAS) + EW'(shift);

        s1_cls_d = CLS_NORM;
        if ((in_exp_a == EXP_MAX && in_exp_b == '0) || (in_exp_a == '0 && in_exp_b == EXP_MAX))
            s1_cls_d = CLS_NAN;
        else if (in_exp_a == EXP_MAX || in_exp_b == EXP_MAX)
            s1_cls_d = CLS_INF;
        else if (in_exp_a == '0 || in_exp_b == '0)
            s1_cls_d = CLS_ZERO;
    end

    // stage 2 next-state
    logic             inc;
    logic [MAN_W+1:0] sum;
    logic [MAN_W-1:0] frac;
    logic [EW-1:0]    exp_r;
    logic [RW-1:0]    s2_result_d;
    logic [3:0]       s2_flags_d;

    // Round, renormalize on carry-out, then pick the special or packed result.
    always_comb begin
`ifdef SSM_FPMUL_RNE_EN
        inc = s1_guard_q & (s1_sticky_q | s1_mant_q[0]);
`else
        inc = 1'b0;
`endif
        sum   = {1'b0, s1_mant_q} + {{(MAN_W+1){1'b0}}, inc};
        frac  = sum[MAN_W-1:0];
        exp_r = s1_exp_q;
        if (sum[MAN_W+1]) begin
            frac  = sum[MAN_W:1];
            exp_r = s1_exp_q + EW'(1);
        end

        s2_result_d = {s1_sign_q, exp_r[EXP_W-1:0], frac};
        s2_flags_d  = {3'b000, s1_guard_q | s1_sticky_q};
        unique case (s1_cls_q)
            CLS_NAN: begin
                s2_result_d = QNAN;
                s2_flags_d  = 4'b1000;
            end
            CLS_INF: begin
                s2_result_d = {s1_sign_q, EXP_MAX, {MAN_W{1'b0}}};
                s2_flags_d  = 4'b0000;
            end
            CLS_ZERO: begin
                s2_result_d = {s1_sign_q, {(RW-1){1'b0}}};
                s2_flags_d  = 4'b0000;
            end
            default: begin
                if (!exp_r[EW-1] && exp_r >= EXP_OVF) begin
                    s2_result_d = {s1_sign_q, EXP_MAX, {MAN_W{1'b0}}};
                    s2_flags_d  = 4'b0101;
                end else if (exp_r[EW-1] || exp_r == '0) begin
                    s2_result_d = {s1_sign_q, {(RW-1){1'b0}}};
                    s2_flags_d  = 4'b0011;
                end
            end
        endcase
    end

    // Stage 1 register: loads whenever the slot is free or draining this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_mant_q   <= '0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_cls_q    <= CLS_NORM;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q   <= s1_sign_d;
                s1_exp_q    <= s1_exp_d;
                s1_mant_q   <= s1_mant_d;
                s1_guard_q  <= s1_guard_d;
                s1_sticky_q <= s1_sticky_d;
                s1_cls_q    <= s1_cls_d;
            end
        end
    end

    // Stage 2 / output register: holds steady while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
        end else if (s2_en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_result_q <= s2_result_d;
                s2_flags_q  <= s2_flags_d;
            end
        end
    end

endmodule
